// File: rtl/mips_icache.sv
// mips_icache: direct-mapped read-only instruction cache with a one-word-per-handshake line refill.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.  Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module mips_icache #(
  parameter int LINES  = 64,
  parameter int WPL    = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
`ifdef ICACHE_STATS_EN
  output logic [31:0]       o_hit_count,
  output logic [31:0]       o_miss_count,
`endif
  input  logic              i_cpu_req,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  output logic [31:0]       o_cpu_rdata,
  output logic              o_cpu_ready,
  input  logic              i_flush,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [31:0]       i_mem_rdata,
  input  logic              i_mem_valid
);

  localparam int OFF_B = $clog2(WPL);
  localparam int OFF_W = (OFF_B > 0) ? OFF_B : 1;
  localparam int IDX_B = $clog2(LINES);
  localparam int TAG_W = ADDR_W - 2 - OFF_B - IDX_B;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_REFILL = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [ADDR_W-1:0] r_base;
  logic [OFF_W-1:0]  r_cnt;
  logic              r_flushed;
  logic [LINES-1:0]  r_valid;
  logic [31:0]       r_data [LINES][WPL];
  logic [TAG_W-1:0]  r_tag  [LINES];

  logic [OFF_W-1:0]  w_off;
  logic [IDX_B-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [IDX_B-1:0]  w_ref_idx;
  logic [TAG_W-1:0]  w_ref_tag;
  logic [ADDR_W-1:0] w_line_base;
  logic              w_hit;
  logic              w_word_done;
  logic              w_last;
  logic              w_unused_ok;

  generate
    if (OFF_B > 0) begin : g_off
      assign w_off = i_cpu_addr[2 +: OFF_W];
    end else begin : g_no_off
      assign w_off = '0;
    end
  endgenerate

  assign w_idx       = i_cpu_addr[2+OFF_B +: IDX_B];
  assign w_tag       = i_cpu_addr[ADDR_W-1 -: TAG_W];
  assign w_line_base = {i_cpu_addr[ADDR_W-1:2+OFF_B], {(2+OFF_B){1'b0}}};
  assign w_ref_idx   = r_base[2+OFF_B +: IDX_B];
  assign w_ref_tag   = r_base[ADDR_W-1 -: TAG_W];
  assign w_unused_ok = &{1'b0, i_cpu_addr[1:0]};

  // mem_valid only counts while a request is actually outstanding
  assign w_word_done = (r_state == S_REFILL) && r_mem_req && i_mem_valid;
  assign w_last      = w_word_done && (r_cnt == OFF_W'(WPL - 1));

  assign o_mem_req  = r_mem_req;
  assign o_mem_addr = r_mem_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hit       = 1'b0;
    o_cpu_ready = 1'b0;
    o_cpu_rdata = '0;
    case (r_state)
      S_IDLE: begin
        // a flush in the same cycle forces the lookup to miss
        w_hit = i_cpu_req && !i_flush && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
        if (w_hit) begin
          o_cpu_ready = 1'b1;
          o_cpu_rdata = r_data[w_idx][w_off];
        end else if (i_cpu_req) begin
          w_state_nxt = S_REFILL;
        end
      end
      S_REFILL: begin
        if (w_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_base     <= '0;
      r_cnt      <= '0;
      r_flushed  <= 1'b0;
      r_valid    <= '0;
    end else begin
      if (i_flush)                    r_valid <= '0;
      else if (w_last && !r_flushed)  r_valid[w_ref_idx] <= 1'b1;

      // remembers a flush seen during the current refill so the line stays invalid
      if (r_state == S_IDLE) r_flushed <= 1'b0;
      else if (i_flush)      r_flushed <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_state_nxt == S_REFILL) begin
            r_base     <= w_line_base;
            r_mem_addr <= w_line_base;
            r_mem_req  <= 1'b1;
            r_cnt      <= '0;
          end
        end
        S_REFILL: begin
          if (r_mem_req) begin
            if (i_mem_valid) begin
              r_mem_req <= 1'b0;
              r_cnt     <= r_cnt + OFF_W'(1);
            end
          end else begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_base + (ADDR_W'(r_cnt) << 2);
          end
        end
        default: r_mem_req <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_word_done) r_data[w_ref_idx][r_cnt] <= i_mem_rdata;
    if (w_last)      r_tag[w_ref_idx] <= w_ref_tag;
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (i_flush) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_hit && (r_hit_count != '1))
        r_hit_count <= r_hit_count + 32'd1;
      if ((r_state == S_IDLE) && (w_state_nxt == S_REFILL) && (r_miss_count != '1))
        r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign o_hit_count  = r_hit_count;
  assign o_miss_count = r_miss_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mips_icache.sv
// tb_mips_icache: directed self-checking bench for mips_icache with a fixed-latency memory model.
`timescale 1ns/1ps
`default_nettype none

module tb_mips_icache;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        stray_valid;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] rd_log[$];

  always #5 clk = ~clk;

  mips_icache #(.LINES(64), .WPL(4), .ADDR_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef ICACHE_STATS_EN
    .o_hit_count (hit_count),
    .o_miss_count(miss_count),
`endif
    .i_cpu_req   (cpu_req),
    .i_cpu_addr  (cpu_addr),
    .o_cpu_rdata (cpu_rdata),
    .o_cpu_ready (cpu_ready),
    .i_flush     (flush),
    .o_mem_req   (mem_req),
    .o_mem_addr  (mem_addr),
    .i_mem_rdata (mem_rdata),
    .i_mem_valid (mem_valid)
  );

  function automatic logic [31:0] model(input logic [31:0] a);
    return 32'h90 + (a >> 2);
  endfunction

  // Memory answers on the LAT-th cycle of a held request
  initial begin
    int lat_cnt;
    lat_cnt   = 0;
    mem_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_valid = 1'b0;
      if (!rst && mem_req) begin
        lat_cnt++;
        if (lat_cnt == LAT) begin
          mem_valid = 1'b1;
          mem_rdata = model(mem_addr);
          rd_log.push_back(mem_addr);
          lat_cnt = 0;
        end
      end else begin
        lat_cnt = 0;
      end
      if (stray_valid) begin
        mem_valid = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
      end
    end
  end

  task automatic fetch(input logic [31:0] a, output logic [31:0] d, output int reads,
                       output int cyc, output bit to);
    int n0;
    n0  = rd_log.size();
    to  = 1'b1;
    cyc = 0;
    d   = '0;
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_addr = a;
    for (int c = 0; c < 300; c++) begin
      #1;
      if (cpu_ready) begin
        d  = cpu_rdata;
        to = 1'b0;
        break;
      end
      cyc++;
      @(negedge clk);
    end
    reads = rd_log.size() - n0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; flush = 1'b0; stray_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_ready: got %b expected 0", cpu_ready); end
    n_checks++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_cpu_rdata: got %h expected 0", cpu_rdata); end
  endtask

  task automatic test_cold_miss();
    logic [31:0] d; int reads, cyc, n0; bit to;
    n0 = rd_log.size();
    fetch(32'h40, d, reads, cyc, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL cold_timeout: got %b expected 0", to); end
    n_checks++; if (reads != 4) begin n_fail++; $display("FAIL cold_reads: got %0d expected 4", reads); end
    for (int k = 0; k < 4; k++) begin
      if (n0 + k < rd_log.size()) begin
        n_checks++;
        if (rd_log[n0+k] !== 32'h40 + 32'(4*k)) begin
          n_fail++; $display("FAIL cold_addr%0d: got %h expected %h", k, rd_log[n0+k], 32'h40 + 32'(4*k));
        end
      end
    end
    n_checks++; if (d !== 32'hA0) begin n_fail++; $display("FAIL cold_data: got %h expected a0", d); end
  endtask

  task automatic test_line_hits();
    logic [31:0] d; int reads, cyc; bit to;
    for (int k = 1; k < 4; k++) begin
      fetch(32'h40 + 32'(4*k), d, reads, cyc, to);
      n_checks++; if (cyc != 0 || to) begin n_fail++; $display("FAIL hit%0d_stall: got %0d stall cycles expected 0", k, cyc); end
      n_checks++; if (d !== 32'hA0 + 32'(k)) begin n_fail++; $display("FAIL hit%0d_data: got %h expected %h", k, d, 32'hA0 + 32'(k)); end
      n_checks++; if (mem_req !== 1'b0 || reads != 0) begin n_fail++; $display("FAIL hit%0d_mem: got req %b reads %0d expected 0 0", k, mem_req, reads); end
    end
  endtask

  task automatic test_conflict();
    logic [31:0] d; int reads, cyc, n0; bit to;
    n0 = rd_log.size();
    fetch(32'h440, d, reads, cyc, to);
    n_checks++; if (reads != 4 || to) begin n_fail++; $display("FAIL conflict_new_reads: got %0d expected 4", reads); end
    n_checks++; if (d !== 32'h1A0) begin n_fail++; $display("FAIL conflict_new_data: got %h expected 1a0", d); end
    if (rd_log.size() > n0) begin
      n_checks++; if (rd_log[n0] !== 32'h440) begin n_fail++; $display("FAIL conflict_addr: got %h expected 440", rd_log[n0]); end
    end
    fetch(32'h40, d, reads, cyc, to);
    n_checks++; if (reads != 4 || to) begin n_fail++; $display("FAIL conflict_old_reads: got %0d expected 4", reads); end
    n_checks++; if (d !== 32'hA0) begin n_fail++; $display("FAIL conflict_old_data: got %h expected a0", d); end
  endtask

  task automatic test_flush();
    logic [31:0] d; int reads, cyc; bit to;
    @(negedge clk);
    flush = 1'b1; cpu_req = 1'b1; cpu_addr = 32'h40;
    #1;
    n_checks++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL flush_same_cycle: got ready %b expected 0", cpu_ready); end
    @(negedge clk);
    flush = 1'b0;
    fetch(32'h40, d, reads, cyc, to);
    n_checks++; if (d !== 32'hA0 || to) begin n_fail++; $display("FAIL flush_refetch_data: got %h expected a0", d); end
    @(negedge clk);
    cpu_req = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    fetch(32'h40, d, reads, cyc, to);
    n_checks++; if (reads != 4 || to) begin n_fail++; $display("FAIL flush_idle_reads: got %0d expected 4", reads); end
  endtask

  task automatic test_flush_refill();
    logic [31:0] d; int reads, cyc, n0; bit to;
    n0 = rd_log.size();
    fork
      fetch(32'h80, d, reads, cyc, to);
      begin
        for (int c = 0; c < 200; c++) begin
          @(negedge clk);
          if (rd_log.size() >= n0 + 1) break;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end
    join
    n_checks++; if (reads != 8 || to) begin n_fail++; $display("FAIL flush_refill_reads: got %0d expected 8", reads); end
    n_checks++; if (d !== 32'hB0) begin n_fail++; $display("FAIL flush_refill_data: got %h expected b0", d); end
    fetch(32'h80, d, reads, cyc, to);
    n_checks++; if (reads != 0 || cyc != 0 || to) begin n_fail++; $display("FAIL flush_refill_rehit: got reads %0d stalls %0d expected 0 0", reads, cyc); end
  endtask

  task automatic test_reset_refill();
    logic [31:0] d; int reads, cyc, n0; bit to;
    n0 = rd_log.size();
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 32'hC0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (rd_log.size() >= n0 + 2) break;
    end
    n_checks++; if (rd_log.size() != n0 + 2) begin n_fail++; $display("FAIL rstrefill_words: got %0d expected 2", rd_log.size() - n0); end
    @(posedge clk);
    #1;
    rst = 1'b1; cpu_req = 1'b0;
    #1;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rstrefill_req_now: got %b expected 0", mem_req); end
    repeat (2) @(negedge clk);
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rstrefill_req_hold: got %b expected 0", mem_req); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    stray_valid = 1'b1;
    @(negedge clk);
    stray_valid = 1'b0;
    repeat (2) @(negedge clk);
    n0 = rd_log.size();
    fetch(32'hC0, d, reads, cyc, to);
    n_checks++; if (reads != 4 || to) begin n_fail++; $display("FAIL rstrefill_reads: got %0d expected 4", reads); end
    if (rd_log.size() > n0) begin
      n_checks++; if (rd_log[n0] !== 32'hC0) begin n_fail++; $display("FAIL rstrefill_first_addr: got %h expected c0", rd_log[n0]); end
    end
    n_checks++; if (d !== 32'hC0) begin n_fail++; $display("FAIL rstrefill_data: got %h expected c0", d); end
  endtask

`ifdef ICACHE_STATS_EN
  task automatic test_stats();
    logic [31:0] d; int reads, cyc; bit to;
    @(negedge clk);
    cpu_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) fetch(32'h40 + 32'(4*k), d, reads, cyc, to);
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    n_checks++; if (miss_count !== 32'd1) begin n_fail++; $display("FAIL stats_miss: got %0d expected 1", miss_count); end
    n_checks++; if (hit_count !== 32'd4) begin n_fail++; $display("FAIL stats_hit: got %0d expected 4", hit_count); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      n_fail++; $display("FAIL stats_flush: got hit %0d miss %0d expected 0 0", hit_count, miss_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_cold_miss();
    test_line_hits();
    test_conflict();
    test_flush();
    test_flush_refill();
    test_reset_refill();
`ifdef ICACHE_STATS_EN
    test_stats();
`endif
    @(negedge clk);
    cpu_req = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
